// File: rtl/mp_arith_pkg.sv
// Shared definitions for the multi-precision arithmetic sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: operation codes, FSM state encoding, word width and word count.
package mp_arith_pkg;

    localparam int WORD_W = 16;
    localparam int WORDS  = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Subtract-class operations invert B in the adder.
    function automatic logic op_is_sub(input op_t op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

endpackage

// File: rtl/mp_arith_seq_if.sv
// Request/result bundle between execute-stage control and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; START is dropped while BUSY is high.
// Signals: START/OP/LEN/OPA/OPB (request), BUSY/DONE (status),
//          RESULT and Z/V/C/N (architectural result and flag registers).
interface mp_arith_seq_if;
    import mp_arith_pkg::*;

    logic                      START;
    logic [1:0]                OP;
    logic [1:0]                LEN;
    logic [WORDS*WORD_W-1:0]   OPA;
    logic [WORDS*WORD_W-1:0]   OPB;
    logic                      BUSY;
    logic                      DONE;
    logic [WORDS*WORD_W-1:0]   RESULT;
    logic                      Z;
    logic                      V;
    logic                      C;
    logic                      N;

    modport master (
        output START, OP, LEN, OPA, OPB,
        input  BUSY, DONE, RESULT, Z, V, C, N
    );

    modport slave (
        input  START, OP, LEN, OPA, OPB,
        output BUSY, DONE, RESULT, Z, V, C, N
    );

endinterface

// File: rtl/comple_adder_16bit_CC.sv
// 16-bit complement adder producing sum and Z/V/C/N condition codes.
// Latency: purely combinational.
// Backpressure: none.
// Ports: A/B operands, ADC/SUB/SBB mode lines (all low = plain ADD), Pre_C
//        carry-in for ADC/SBB; S sum, C carry-out (1 = no borrow), V signed
//        overflow, Z sum is zero, N sum bit 15.
module comple_adder_16bit_CC (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        ADC,
    input  logic        SUB,
    input  logic        SBB,
    input  logic        Pre_C,
    output logic [15:0] S,
    output logic        C,
    output logic        V,
    output logic        Z,
    output logic        N
);

    logic [15:0] b_eff;
    logic        cin;
    logic [16:0] sum;

    always_comb begin
        b_eff = (SUB || SBB) ? ~B : B;
        // SUB forces the +1 of two's complement; ADC/SBB chain the caller's carry.
        if (SUB)
            cin = 1'b1;
        else if (ADC || SBB)
            cin = Pre_C;
        else
            cin = 1'b0;
        sum = {1'b0, A} + {1'b0, b_eff} + {16'b0, cin};
        S   = sum[15:0];
        C   = sum[16];
        // Overflow: both effective operands share a sign the sum does not.
        V   = (A[15] == b_eff[15]) && (sum[15] != A[15]);
        Z   = (sum[15:0] == 16'h0000);
        N   = sum[15];
    end

endmodule

// File: rtl/mp_arith_seq.sv
// Multi-precision ADD/ADC/SUB/SBB sequencer stepping a 16-bit adder LS word first.
// Latency: LEN+1 cycles from accepted START to the one-cycle DONE pulse.
// Backpressure: START is ignored while BUSY; holding START in DONE chains ops back to back.
// Ports: CLK, RST_n (async active-low), bus (slave side of mp_arith_seq_if):
//        request START/OP/LEN/OPA/OPB, status BUSY/DONE, RESULT and Z/V/C/N flags.
module mp_arith_seq
    import mp_arith_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_n,
    mp_arith_seq_if.slave bus
);

    localparam int DW = WORDS * WORD_W;

    state_t           state_q, state_d;
    logic [DW-1:0]    opa_q, opb_q, result_q;
    op_t              op_q;
    logic [1:0]       len_q;
    logic [1:0]       k_q;
    logic             chain_q;
    logic             z_acc_q;
    logic             z_q, v_q, c_q, n_q;

    logic             accept;
    logic             last_word;
    logic [5:0]       bit_base;
    logic [15:0]      a_word, b_word, s_word;
    logic             adc_w, sub_w, sbb_w, pre_c_w;
    logic             c_w, v_w, z_w, n_w;

    assign accept    = bus.START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_word = (k_q == len_q);
    assign bit_base  = {k_q, 4'b0000};
    assign a_word    = opa_q[bit_base +: WORD_W];
    assign b_word    = opb_q[bit_base +: WORD_W];

    // Word 0 runs the requested op with the architectural C as carry-in;
    // higher words always chain through the internal carry register.
    always_comb begin
        adc_w   = 1'b0;
        sub_w   = 1'b0;
        sbb_w   = 1'b0;
        pre_c_w = chain_q;
        if (k_q == 2'd0) begin
            pre_c_w = c_q;
            case (op_q)
                OP_ADC:  adc_w = 1'b1;
                OP_SUB:  sub_w = 1'b1;
                OP_SBB:  sbb_w = 1'b1;
                default: ;
            endcase
        end else if (op_is_sub(op_q)) begin
            sbb_w = 1'b1;
        end else begin
            adc_w = 1'b1;
        end
    end

    comple_adder_16bit_CC u_adder (
        .A     (a_word),
        .B     (b_word),
        .ADC   (adc_w),
        .SUB   (sub_w),
        .SBB   (sbb_w),
        .Pre_C (pre_c_w),
        .S     (s_word),
        .C     (c_w),
        .V     (v_w),
        .Z     (z_w),
        .N     (n_w)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_word) state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= OP_ADD;
            len_q    <= '0;
            k_q      <= '0;
            chain_q  <= 1'b0;
            z_acc_q  <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
        end else if (accept) begin
            opa_q   <= bus.OPA;
            opb_q   <= bus.OPB;
            op_q    <= op_t'(bus.OP);
            len_q   <= bus.LEN;
            k_q     <= '0;
            z_acc_q <= 1'b1;
            // Words beyond the new length would otherwise show stale data.
            for (int i = 0; i < WORDS; i++) begin
                if (i > int'(bus.LEN))
                    result_q[i*WORD_W +: WORD_W] <= '0;
            end
        end else if (state_q == ST_RUN) begin
            result_q[bit_base +: WORD_W] <= s_word;
            chain_q <= c_w;
            z_acc_q <= z_acc_q & z_w;
            if (last_word) begin
                // Flags only move here, so an aborted op leaves no partial update.
                c_q <= c_w;
                v_q <= v_w;
                n_q <= n_w;
                z_q <= z_acc_q & z_w;
            end else begin
                k_q <= k_q + 2'd1;
            end
        end
    end

    assign bus.BUSY   = (state_q == ST_RUN);
    assign bus.DONE   = (state_q == ST_DONE);
    assign bus.RESULT = result_q;
    assign bus.Z      = z_q;
    assign bus.V      = v_q;
    assign bus.C      = c_q;
    assign bus.N      = n_q;

endmodule

// File: tb/tb_mp_arith_seq.sv
// Self-checking bench for mp_arith_seq: directed corner vectors, randomized ops
// against a full-width arithmetic reference model, and control-path corners.
// Holds the model copy of the C flag so ADC/SBB word-0 carry-in can be predicted.
module tb_mp_arith_seq;
    import mp_arith_pkg::*;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    mp_arith_seq_if bus();

    mp_arith_seq dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] r;
        logic        z;
        logic        v;
        logic        c;
        logic        n;
    } res_t;

    typedef struct {
        int   busy;
        bit   done_seen;
        bit   overlap;
        logic done_after;
        logic busy_after;
        res_t got;
    } obs_t;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  len;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_r;
        logic [3:0]  exp_zvcn;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_c      = 1'b0;

    // Reference: one (LEN+1)*16-bit addition with the op's carry-in rule.
    function automatic res_t model(input logic [1:0] op, input logic [1:0] len,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic cin);
        int          nb;
        logic [64:0] mask, aa, bb, s;
        logic        ci;
        res_t        m;
        nb   = (int'(len) + 1) * 16;
        mask = (65'd1 << nb) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = (op[1] ? {1'b0, ~b} : {1'b0, b}) & mask;
        ci   = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cin;
        s    = aa + bb + {64'b0, ci};
        m.r  = s[63:0] & mask[63:0];
        m.c  = s[nb];
        m.n  = s[nb-1];
        m.v  = (aa[nb-1] == bb[nb-1]) && (s[nb-1] != aa[nb-1]);
        m.z  = (m.r == 64'b0);
        return m;
    endfunction

    task automatic launch(input logic [1:0] op, input logic [1:0] len,
                          input logic [63:0] a, input logic [63:0] b, output obs_t o);
        o.busy = 0; o.done_seen = 0; o.overlap = 0; o.got = '0;
        o.done_after = 1'b1; o.busy_after = 1'b1;
        @(negedge CLK);
        bus.START = 1'b1; bus.OP = op; bus.LEN = len; bus.OPA = a; bus.OPB = b;
        @(posedge CLK);
        #1;
        // Scramble inputs after acceptance; the captured copy must be used.
        bus.START = 1'b0;
        bus.OPA = {$urandom, $urandom};
        bus.OPB = {$urandom, $urandom};
        bus.OP  = 2'($urandom);
        bus.LEN = 2'($urandom);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.BUSY && bus.DONE) o.overlap = 1;
            if (bus.BUSY) o.busy = o.busy + 1;
            if (bus.DONE) begin
                o.done_seen = 1;
                o.got = {bus.RESULT, bus.Z, bus.V, bus.C, bus.N};
                break;
            end
        end
        @(negedge CLK);
        o.done_after = bus.DONE;
        o.busy_after = bus.BUSY;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({bus.BUSY, bus.DONE, bus.RESULT, bus.Z, bus.V, bus.C, bus.N} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: busy=%b done=%b result=%h zvcn=%b required all 0",
                     bus.BUSY, bus.DONE, bus.RESULT, {bus.Z, bus.V, bus.C, bus.N});
        end
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({bus.BUSY, bus.DONE, bus.RESULT, bus.Z, bus.V, bus.C, bus.N} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: busy=%b done=%b result=%h zvcn=%b required all 0",
                     bus.BUSY, bus.DONE, bus.RESULT, {bus.Z, bus.V, bus.C, bus.N});
        end
        RST_n = 1'b1;
        m_c = 1'b0;
    endtask

    task automatic test_directed();
        vec_t tbl[8];
        obs_t o;
        tbl[0] = '{2'b00, 2'd0, 64'h1234, 64'h2345, 64'h3579, 4'b0000};
        tbl[1] = '{2'b11, 2'd0, 64'h1234, 64'h2345, 64'hEEEE, 4'b0001};
        tbl[2] = '{2'b00, 2'd1, 64'h0000FFFF, 64'h1, 64'h00010000, 4'b0000};
        tbl[3] = '{2'b10, 2'd1, 64'h00010000, 64'h1, 64'h0000FFFF, 4'b0010};
        tbl[4] = '{2'b00, 2'd3, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 4'b1010};
        tbl[5] = '{2'b01, 2'd0, 64'h0, 64'h0, 64'h0001, 4'b0000};
        tbl[6] = '{2'b10, 2'd0, 64'h1234, 64'h2345, 64'hEEEF, 4'b0001};
        tbl[7] = '{2'b00, 2'd0, 64'h7FFF, 64'h0001, 64'h8000, 4'b0101};
        for (int i = 0; i < 8; i++) begin
            launch(tbl[i].op, tbl[i].len, tbl[i].a, tbl[i].b, o);
            n_checks++;
            if (o.got !== {tbl[i].exp_r, tbl[i].exp_zvcn}) begin
                n_fail++;
                $display("FAIL directed[%0d] result/flags: got %h zvcn=%b required %h zvcn=%b",
                         i, o.got.r, {o.got.z, o.got.v, o.got.c, o.got.n},
                         tbl[i].exp_r, tbl[i].exp_zvcn);
            end
            n_checks++;
            if (o.busy != int'(tbl[i].len) + 1 || !o.done_seen || o.overlap) begin
                n_fail++;
                $display("FAIL directed[%0d] timing: busy_cycles=%0d done_seen=%0d overlap=%0d required busy_cycles=%0d done_seen=1 overlap=0",
                         i, o.busy, o.done_seen, o.overlap, int'(tbl[i].len) + 1);
            end
            n_checks++;
            if (o.done_after !== 1'b0 || o.busy_after !== 1'b0) begin
                n_fail++;
                $display("FAIL directed[%0d] done_pulse: after-done done=%b busy=%b required 0 0",
                         i, o.done_after, o.busy_after);
            end
            m_c = tbl[i].exp_zvcn[1];
        end
    endtask

    task automatic test_random();
        obs_t        o;
        res_t        e;
        logic [1:0]  op, len;
        logic [63:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom);
            len = 2'($urandom);
            a   = {$urandom, $urandom};
            b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            e   = model(op, len, a, b, m_c);
            launch(op, len, a, b, o);
            n_checks++;
            if (o.got !== e || o.busy != int'(len) + 1 || !o.done_seen || o.overlap) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d len=%0d: got %h zvcn=%b busy=%0d required %h zvcn=%b busy=%0d",
                         i, op, len, o.got.r, {o.got.z, o.got.v, o.got.c, o.got.n}, o.busy,
                         e.r, {e.z, e.v, e.c, e.n}, int'(len) + 1);
            end
            m_c = e.c;
        end
    endtask

    task automatic test_start_mid_run();
        res_t        e;
        logic [63:0] a, b;
        int          busy;
        bit          seen;
        res_t        got;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        e = model(2'b10, 2'd3, a, b, m_c);
        busy = 0; seen = 0; got = '0;
        @(negedge CLK);
        bus.START = 1'b1; bus.OP = 2'b10; bus.LEN = 2'd3; bus.OPA = a; bus.OPB = b;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.BUSY) busy++;
            if (bus.DONE) begin
                seen = 1;
                got = {bus.RESULT, bus.Z, bus.V, bus.C, bus.N};
                bus.START = 1'b0;
                break;
            end
            if (i == 1) begin
                bus.START = 1'b1; bus.OP = 2'b00; bus.LEN = 2'd0;
                bus.OPA = {$urandom, $urandom}; bus.OPB = {$urandom, $urandom};
            end else begin
                bus.START = 1'b0;
            end
        end
        n_checks++;
        if (!seen || got !== e || busy != 4) begin
            n_fail++;
            $display("FAIL mid_run_start: got %h zvcn=%b busy=%0d required %h zvcn=%b busy=4",
                     got.r, {got.z, got.v, got.c, got.n}, busy, e.r, {e.z, e.v, e.c, e.n});
        end
        m_c = e.c;
        @(negedge CLK);
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_no_queue: busy=%b done=%b required 0 0", bus.BUSY, bus.DONE);
        end
    endtask

    task automatic test_back_to_back();
        res_t        e1, e2, got;
        logic [63:0] a1, b1, a2, b2;
        int          busy;
        bit          seen;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        e1 = model(2'b00, 2'd1, a1, b1, m_c);
        e2 = model(2'b11, 2'd2, a2, b2, e1.c);
        @(negedge CLK);
        bus.START = 1'b1; bus.OP = 2'b00; bus.LEN = 2'd1; bus.OPA = a1; bus.OPB = b1;
        @(posedge CLK);
        #1;
        bus.OP = 2'b11; bus.LEN = 2'd2; bus.OPA = a2; bus.OPB = b2;
        seen = 0; got = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.DONE) begin
                seen = 1;
                got = {bus.RESULT, bus.Z, bus.V, bus.C, bus.N};
                break;
            end
        end
        n_checks++;
        if (!seen || got !== e1) begin
            n_fail++;
            $display("FAIL b2b_first: got %h zvcn=%b required %h zvcn=%b",
                     got.r, {got.z, got.v, got.c, got.n}, e1.r, {e1.z, e1.v, e1.c, e1.n});
        end
        @(posedge CLK);
        #1 bus.START = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_idle: busy=%b done=%b required 1 0", bus.BUSY, bus.DONE);
        end
        busy = 1; seen = 0; got = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (bus.BUSY) busy++;
            if (bus.DONE) begin
                seen = 1;
                got = {bus.RESULT, bus.Z, bus.V, bus.C, bus.N};
                break;
            end
        end
        n_checks++;
        if (!seen || got !== e2 || busy != 3) begin
            n_fail++;
            $display("FAIL b2b_second: got %h zvcn=%b busy=%0d required %h zvcn=%b busy=3",
                     got.r, {got.z, got.v, got.c, got.n}, busy, e2.r, {e2.z, e2.v, e2.c, e2.n});
        end
        m_c = e2.c;
    endtask

    task automatic test_reset_mid_run();
        obs_t o;
        // Leave C=1, N=1 so a surviving flag would be visible.
        launch(2'b00, 2'd0, 64'hFFFF, 64'hFFFF, o);
        n_checks++;
        if (o.got !== {64'hFFFE, 4'b0011}) begin
            n_fail++;
            $display("FAIL pre_reset_op: got %h zvcn=%b required fffe zvcn=0011",
                     o.got.r, {o.got.z, o.got.v, o.got.c, o.got.n});
        end
        @(negedge CLK);
        bus.START = 1'b1; bus.OP = 2'b00; bus.LEN = 2'd3;
        bus.OPA = {$urandom, $urandom}; bus.OPB = {$urandom, $urandom};
        @(posedge CLK);
        #1 bus.START = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.BUSY, bus.DONE, bus.RESULT, bus.Z, bus.V, bus.C, bus.N} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%h zvcn=%b required all 0",
                     bus.BUSY, bus.DONE, bus.RESULT, {bus.Z, bus.V, bus.C, bus.N});
        end
        @(negedge CLK);
        RST_n = 1'b1;
        m_c = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.RESULT !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b result=%h required 0 0 0",
                     bus.BUSY, bus.DONE, bus.RESULT);
        end
        // ADC with cleared C must give 0, not 1.
        launch(2'b01, 2'd0, 64'h0, 64'h0, o);
        n_checks++;
        if (o.got !== {64'h0, 4'b1000} || o.busy != 1) begin
            n_fail++;
            $display("FAIL post_reset_adc: got %h zvcn=%b busy=%0d required 0 zvcn=1000 busy=1",
                     o.got.r, {o.got.z, o.got.v, o.got.c, o.got.n}, o.busy);
        end
    endtask

    initial begin
        bus.START = 1'b0;
        bus.OP    = 2'b00;
        bus.LEN   = 2'b00;
        bus.OPA   = '0;
        bus.OPB   = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_mid_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
